// File: rtl/pwm_hum_ctrl.sv
// Humidity-banded PWM generator: hysteretic 4-band classifier feeding a fixed-period PWM.
// Optional soft-start duty slewing is built when PWM_HUM_RAMP_EN is defined.
module pwm_hum_ctrl #(
    parameter int CNT_W     = 10,
    parameter int PERIOD    = 999,
    parameter int PRESCALE  = 1,
    parameter int TH_LO     = 20,
    parameter int TH_MID    = 50,
    parameter int TH_HI     = 80,
    parameter int HYST      = 2,
    parameter int DUTY0_PCT = 20,
    parameter int DUTY1_PCT = 50,
    parameter int DUTY2_PCT = 80,
    parameter int RAMP_STEP = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             hum_valid,
    input  logic [6:0]       humidity,
    output logic             pwm,
    output logic [CNT_W-1:0] duty_now,
    output logic [1:0]       band,
    output logic             period_tick
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] T0 = CNT_W'(((PERIOD + 1) * DUTY0_PCT) / 100);
    localparam logic [CNT_W-1:0] T1 = CNT_W'(((PERIOD + 1) * DUTY1_PCT) / 100);
    localparam logic [CNT_W-1:0] T2 = CNT_W'(((PERIOD + 1) * DUTY2_PCT) / 100);

    if (PERIOD >= (1 << CNT_W) || PRESCALE < 1 || RAMP_STEP < 1) begin : g_bad_param
        $error("pwm_hum_ctrl: PERIOD must fit CNT_W, PRESCALE and RAMP_STEP must be >= 1");
    end

    typedef enum logic [1:0] {B0 = 2'd0, B1 = 2'd1, B2 = 2'd2, B3 = 2'd3} band_t;

    band_t            band_q, band_nx;
    logic [6:0]       h_q;
    logic [PS_W-1:0]  ps;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] duty_next;
    logic             ce;

    assign ce          = (ps == PS_LAST);
    assign period_tick = enable && ce && (cnt == CNT_LAST);
    assign band        = band_q;

    // Out-of-range readings saturate so band 3 still resolves sensibly.
    always_ff @(posedge clk) begin
        if (rst)
            h_q <= 7'd99;
        else if (hum_valid)
            h_q <= (humidity > 7'd99) ? 7'd99 : humidity;
    end

    always_ff @(posedge clk) begin
        if (rst) band_q <= B3;
        else     band_q <= band_nx;
    end

    // Up at the band's upper edge, down only once HYST below its lower edge.
    always_comb begin
        band_nx = band_q;
        unique case (band_q)
            B0: if (int'(h_q) >= TH_LO) band_nx = B1;
            B1: begin
                if (int'(h_q) >= TH_MID)            band_nx = B2;
                else if (int'(h_q) < TH_LO - HYST)  band_nx = B0;
            end
            B2: begin
                if (int'(h_q) >= TH_HI)             band_nx = B3;
                else if (int'(h_q) < TH_MID - HYST) band_nx = B1;
            end
            B3: if (int'(h_q) < TH_HI - HYST) band_nx = B2;
        endcase
    end

    always_comb begin
        target = '0;
        unique case (band_q)
            B0: target = T0;
            B1: target = T1;
            B2: target = T2;
            B3: target = '0;
        endcase
    end

`ifdef PWM_HUM_RAMP_EN
    localparam logic [CNT_W-1:0] RAMP_C = CNT_W'(RAMP_STEP);

    // Step toward target, landing exactly on it when within one step.
    always_comb begin
        duty_next = duty_now;
        if (duty_now < target) begin
            if (target - duty_now <= RAMP_C) duty_next = target;
            else                             duty_next = duty_now + RAMP_C;
        end else if (duty_now > target) begin
            if (duty_now - target <= RAMP_C) duty_next = target;
            else                             duty_next = duty_now - RAMP_C;
        end
    end
`else
    assign duty_next = target;
`endif

    // Duty only moves on the terminal count, so each period sees one duty value.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            ps       <= '0;
            cnt      <= '0;
            duty_now <= '0;
            pwm      <= 1'b0;
        end else begin
            pwm <= (cnt < duty_now);
            ps  <= ce ? '0 : ps + PS_W'(1);
            if (ce)
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            if (period_tick)
                duty_now <= duty_next;
        end
    end

endmodule

// File: tb/tb_pwm_hum_ctrl.sv
// Directed bench for pwm_hum_ctrl with default parameters; duty expectations follow
// PWM_HUM_RAMP_EN so the same bench covers both builds.
module tb_pwm_hum_ctrl;

`ifdef PWM_HUM_RAMP_EN
    localparam bit RAMP   = 1'b1;
    localparam int RAMP_N = 20;
`else
    localparam bit RAMP   = 1'b0;
    localparam int RAMP_N = 2;
`endif

    logic       clk = 1'b0;
    logic       rst, enable, hum_valid;
    logic [6:0] humidity;
    logic       pwm;
    logic [9:0] duty_now;
    logic [1:0] band;
    logic       period_tick;

    int checks = 0;
    int errors = 0;
    int exp_duty = 0;
    int exp_tgt  = 0;
    int n, hi, held;

    pwm_hum_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .hum_valid(hum_valid),
        .humidity(humidity), .pwm(pwm), .duty_now(duty_now), .band(band),
        .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    function automatic int nxt(input int cur, input int tgt);
        int r;
        r = tgt;
        if (RAMP) begin
            if (cur < tgt)      r = (cur + 10 > tgt) ? tgt : cur + 10;
            else if (cur > tgt) r = (cur - 10 < tgt) ? tgt : cur - 10;
            else                r = cur;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Walk negedges to the next period_tick; count clocks and pwm-high samples.
    task automatic tick_wait(output int cyc, output int highs);
        cyc = 0;
        highs = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (pwm) highs++;
        end while (!period_tick && cyc < 2000);
        check("tick_found", {31'd0, period_tick}, 1);
        exp_duty = nxt(exp_duty, exp_tgt);
    endtask

    task automatic apply(input logic [6:0] v);
        hum_valid = 1'b1;
        humidity  = v;
        @(negedge clk);
        hum_valid = 1'b0;
    endtask

    task automatic settle_band(input string tag, input int exp_band);
        repeat (3) @(negedge clk);
        check(tag, {30'd0, band}, exp_band);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; hum_valid = 1'b0; humidity = '0;
        repeat (3) @(negedge clk);
        check("rst_pwm",  {31'd0, pwm}, 0);
        check("rst_duty", {22'd0, duty_now}, 0);
        check("rst_band", {30'd0, band}, 3);
        check("rst_tick", {31'd0, period_tick}, 0);

        // 1: idle periods, band 3, output off
        rst = 1'b0;
        tick_wait(n, hi);
        check("first_tick_clocks", n, 999);
        check("idle_pwm_p1", hi, 0);
        tick_wait(n, hi);
        check("tick_spacing_p2", n, 1000);
        check("idle_pwm_p2", hi, 0);
        tick_wait(n, hi);
        check("tick_spacing_p3", n, 1000);
        check("idle_pwm_p3", hi, 0);
        check("idle_band", {30'd0, band}, 3);

        // 2: 35 % -> band 3, 2, 1 on consecutive clocks, duty 500
        repeat (5) @(negedge clk);
        apply(7'd35);
        check("b35_c0", {30'd0, band}, 3);
        @(negedge clk);
        check("b35_c1", {30'd0, band}, 2);
        @(negedge clk);
        check("b35_c2", {30'd0, band}, 1);
        exp_tgt = 500;
        tick_wait(n, hi);
        @(negedge clk);
        check("duty_b1", {22'd0, duty_now}, exp_duty);
        held = exp_duty;
        tick_wait(n, hi);
        check("pwm_high_b1", hi, held);

        // 3: hysteresis around TH_MID and TH_LO
        apply(7'd50); settle_band("hys_50", 2);
        apply(7'd49); settle_band("hys_49", 2);
        apply(7'd47); settle_band("hys_47", 1);
        apply(7'd18); settle_band("hys_18", 1);
        apply(7'd17); settle_band("hys_17", 0);
        apply(7'd19); settle_band("hys_19", 0);
        exp_tgt = 200;
        tick_wait(n, hi);
        @(negedge clk);
        check("duty_b0", {22'd0, duty_now}, exp_duty);

        // 4: from duty 0 toward 200, then sample 90 during the tick cycle
        enable = 1'b0;
        @(negedge clk);
        check("dis_duty", {22'd0, duty_now}, 0);
        check("dis_pwm", {31'd0, pwm}, 0);
        exp_duty = 0;
        enable = 1'b1;
        for (int k = 0; k < RAMP_N; k++) begin
            tick_wait(n, hi);
            @(negedge clk);
            check("ramp_up", {22'd0, duty_now}, exp_duty);
        end
        check("ramp_top", {22'd0, duty_now}, 200);
        tick_wait(n, hi);
        apply(7'd90);
        check("same_cycle_duty", {22'd0, duty_now}, exp_duty);
        check("same_cycle_band", {30'd0, band}, 0);
        settle_band("b90", 3);
        exp_tgt = 0;
        for (int k = 0; k < RAMP_N; k++) begin
            tick_wait(n, hi);
            @(negedge clk);
            check("ramp_down", {22'd0, duty_now}, exp_duty);
        end
        check("ramp_bottom", {22'd0, duty_now}, 0);

        // 5: disable at counter 300, re-enable restarts the period
        apply(7'd35); settle_band("b35_again", 1);
        exp_tgt = 500;
        tick_wait(n, hi);
        repeat (301) @(negedge clk);
        check("pwm_at_300", {31'd0, pwm}, (299 < exp_duty) ? 1 : 0);
        enable = 1'b0;
        @(negedge clk);
        check("off_pwm",  {31'd0, pwm}, 0);
        check("off_duty", {22'd0, duty_now}, 0);
        check("off_tick", {31'd0, period_tick}, 0);
        exp_duty = 0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        tick_wait(n, hi);
        check("reen_tick_clocks", n, 999);
        @(negedge clk);
        check("reen_duty", {22'd0, duty_now}, exp_duty);

        // 6: out-of-range humidity, then reset mid-period
        repeat (100) @(negedge clk);
        apply(7'd120);
        settle_band("clamp_band", 3);
        check("pre_rst_pwm", {31'd0, pwm}, (exp_duty > 200) ? 1 : 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_pwm",  {31'd0, pwm}, 0);
        check("mid_rst_duty", {22'd0, duty_now}, 0);
        check("mid_rst_band", {30'd0, band}, 3);
        check("mid_rst_tick", {31'd0, period_tick}, 0);
        rst = 1'b0;
        exp_duty = 0;
        exp_tgt  = 0;
        tick_wait(n, hi);
        check("post_rst_tick_clocks", n, 999);
        check("post_rst_pwm", hi, 0);
        @(negedge clk);
        check("post_rst_duty", {22'd0, duty_now}, 0);
        check("post_rst_band", {30'd0, band}, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
